branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit_pkg.sv | 32 +++
 rtl/branch_predict_unit_cmp.sv | 55 +++++
 rtl/branch_predict_unit.sv | 98 +++++++++
 tb/tb_branch_predict_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_predict_unit_pkg: opcodes, funct3 codes, BHT counter states.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package branch_predict_unit_pkg;

  localparam logic [6:0] c_B_TYPE  = 7'b1100011;
  localparam logic [2:0] c_F3_BEQ  = 3'b000;
  localparam logic [2:0] c_F3_BNE  = 3'b001;
  localparam logic [2:0] c_F3_BLT  = 3'b100;
  localparam logic [2:0] c_F3_BGE  = 3'b101;
  localparam logic [2:0] c_F3_BLTU = 3'b110;
  localparam logic [2:0] c_F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  // Saturating step of a 2-bit counter toward taken or not-taken.
  function automatic bht_state_e bht_next(input bht_state_e s, input logic taken);
    if (taken) begin
      return (s == ST) ? ST : bht_state_e'(s + 2'd1);
    end
    return (s == SNT) ? SNT : bht_state_e'(s - 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_unit_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_cmp: operand compare and branch outcome resolution.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module branch_cmp
  import branch_predict_unit_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              ex_valid_i,
  input  logic [6:0]        ex_opcode_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [DWIDTH-1:0] ex_rs1_i,
  input  logic [DWIDTH-1:0] ex_rs2_i,
  input  logic              ex_pred_taken_i,
  output logic              breq_o,
  output logic              brlt_o,
  output logic              is_branch_o,
  output logic              ex_taken_o,
  output logic              ex_mispredict_o
);

  logic w_is_b_type;
  logic w_unsigned;
  logic w_lt;
  logic w_funct3_ok;
  logic w_taken_raw;

  assign w_is_b_type = (ex_opcode_i == c_B_TYPE);
  assign w_unsigned  = (ex_funct3_i == c_F3_BLTU) || (ex_funct3_i == c_F3_BGEU);
  assign w_lt        = w_unsigned ? (ex_rs1_i < ex_rs2_i)
                                  : ($signed(ex_rs1_i) < $signed(ex_rs2_i));

  assign breq_o = w_is_b_type && (ex_rs1_i == ex_rs2_i);
  assign brlt_o = w_is_b_type && w_lt;

  always_comb begin
    w_funct3_ok = 1'b1;
    w_taken_raw = 1'b0;
    case (ex_funct3_i)
      c_F3_BEQ:              w_taken_raw = breq_o;
      c_F3_BNE:              w_taken_raw = !breq_o;
      c_F3_BLT, c_F3_BLTU:   w_taken_raw = brlt_o;
      c_F3_BGE, c_F3_BGEU:   w_taken_raw = !brlt_o;
      default:               w_funct3_ok = 1'b0;
    endcase
  end

  assign is_branch_o     = ex_valid_i && w_is_b_type && w_funct3_ok;
  assign ex_taken_o      = is_branch_o && w_taken_raw;
  assign ex_mispredict_o = is_branch_o && (ex_taken_o != ex_pred_taken_i);

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_predict_unit: flop-based 2-bit BHT, branch resolve, stats.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CWIDTH      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              f_valid_i,
  input  logic [AWIDTH-1:0] f_pc_i,
  output logic              f_pred_taken_o,
  input  logic              ex_valid_i,
  input  logic [6:0]        ex_opcode_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [AWIDTH-1:0] ex_pc_i,
  input  logic [DWIDTH-1:0] ex_rs1_i,
  input  logic [DWIDTH-1:0] ex_rs2_i,
  input  logic              ex_pred_taken_i,
  output logic              breq_o,
  output logic              brlt_o,
  output logic              ex_taken_o,
  output logic              ex_mispredict_o,
  output logic [CWIDTH-1:0] branch_cnt_o,
  output logic [CWIDTH-1:0] mispred_cnt_o
);

  localparam int c_IDX_W = $clog2(BHT_ENTRIES);

  logic [c_IDX_W-1:0] w_f_idx;
  logic [c_IDX_W-1:0] w_ex_idx;
  bht_state_e         w_f_state;
  bht_state_e         r_bht [BHT_ENTRIES];
  logic               w_is_branch;
  logic [CWIDTH-1:0]  r_branch_cnt;
  logic [CWIDTH-1:0]  r_mispred_cnt;
  logic               w_unused_pc;

  // Word-aligned PCs: the two low bits never reach the index.
  assign w_f_idx     = f_pc_i[c_IDX_W+1:2];
  assign w_ex_idx    = ex_pc_i[c_IDX_W+1:2];
  assign w_unused_pc = ^{f_pc_i, ex_pc_i};

  branch_cmp #(
    .DWIDTH (DWIDTH)
  ) u_cmp (
    .ex_valid_i      (ex_valid_i),
    .ex_opcode_i     (ex_opcode_i),
    .ex_funct3_i     (ex_funct3_i),
    .ex_rs1_i        (ex_rs1_i),
    .ex_rs2_i        (ex_rs2_i),
    .ex_pred_taken_i (ex_pred_taken_i),
    .breq_o          (breq_o),
    .brlt_o          (brlt_o),
    .is_branch_o     (w_is_branch),
    .ex_taken_o      (ex_taken_o),
    .ex_mispredict_o (ex_mispredict_o)
  );

  // Reads see the registered value, so a same-cycle update is not bypassed.
  assign w_f_state      = r_bht[w_f_idx];
  assign f_pred_taken_o = f_valid_i && ((w_f_state == WT) || (w_f_state == ST));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= WNT;
      end
    end else if (w_is_branch) begin
      r_bht[w_ex_idx] <= bht_next(r_bht[w_ex_idx], ex_taken_o);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_is_branch && (r_branch_cnt != {CWIDTH{1'b1}})) begin
        r_branch_cnt <= r_branch_cnt + CWIDTH'(1);
      end
      if (ex_mispredict_o && (r_mispred_cnt != {CWIDTH{1'b1}})) begin
        r_mispred_cnt <= r_mispred_cnt + CWIDTH'(1);
      end
    end
  end

  assign branch_cnt_o  = r_branch_cnt;
  assign mispred_cnt_o = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_branch_predict_unit: vector table, corner sequences, random model. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_valid = 1'b0;
  logic [31:0] f_pc = '0;
  logic        ex_valid = 1'b0;
  logic [6:0]  ex_opcode = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_rs1 = '0;
  logic [31:0] ex_rs2 = '0;
  logic        ex_pred = 1'b0;

  logic        f_pred, breq, brlt, taken, mis;
  logic [15:0] bcnt, mcnt;
  logic        f_pred4, breq4, brlt4, taken4, mis4;
  logic [3:0]  bcnt4, mcnt4;

  int n_cmp = 0;
  int n_bad = 0;

  int bht_m [64];
  int bcnt_m, mcnt_m, bcnt4_m, mcnt4_m;

  typedef struct {
    logic        v;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
    logic        breq;
    logic        brlt;
    logic        taken;
    logic        mis;
    int          db;
    int          dm;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .f_valid_i(f_valid), .f_pc_i(f_pc),
    .f_pred_taken_o(f_pred), .ex_valid_i(ex_valid), .ex_opcode_i(ex_opcode),
    .ex_funct3_i(ex_funct3), .ex_pc_i(ex_pc), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2),
    .ex_pred_taken_i(ex_pred), .breq_o(breq), .brlt_o(brlt), .ex_taken_o(taken),
    .ex_mispredict_o(mis), .branch_cnt_o(bcnt), .mispred_cnt_o(mcnt)
  );

  branch_predict_unit #(.CWIDTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .f_valid_i(f_valid), .f_pc_i(f_pc),
    .f_pred_taken_o(f_pred4), .ex_valid_i(ex_valid), .ex_opcode_i(ex_opcode),
    .ex_funct3_i(ex_funct3), .ex_pc_i(ex_pc), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2),
    .ex_pred_taken_i(ex_pred), .breq_o(breq4), .brlt_o(brlt4), .ex_taken_o(taken4),
    .ex_mispredict_o(mis4), .branch_cnt_o(bcnt4), .mispred_cnt_o(mcnt4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    bcnt_m = 0; mcnt_m = 0; bcnt4_m = 0; mcnt4_m = 0;
  endfunction

  // Outcome derived straight from the instruction semantics.
  function automatic void model_comb(output logic isb, output logic eq, output logic lt,
                                     output logic tk, output logic mp);
    logic btype;
    btype = (ex_opcode == 7'h63);
    eq = btype && (ex_rs1 == ex_rs2);
    if (ex_funct3 == 3'd6 || ex_funct3 == 3'd7) lt = btype && (ex_rs1 < ex_rs2);
    else lt = btype && ($signed(ex_rs1) < $signed(ex_rs2));
    isb = ex_valid && btype && !(ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
    case (ex_funct3)
      3'd0:       tk = eq;
      3'd1:       tk = !eq;
      3'd4, 3'd6: tk = lt;
      3'd5, 3'd7: tk = !lt;
      default:    tk = 1'b0;
    endcase
    tk = isb && tk;
    mp = isb && (tk != ex_pred);
  endfunction

  function automatic logic model_pred();
    return f_valid && (bht_m[(f_pc >> 2) % 64] >= 2);
  endfunction

  function automatic void model_update();
    logic isb, eq, lt, tk, mp;
    int idx;
    model_comb(isb, eq, lt, tk, mp);
    idx = (ex_pc >> 2) % 64;
    if (isb) begin
      if (tk && bht_m[idx] < 3) bht_m[idx]++;
      if (!tk && bht_m[idx] > 0) bht_m[idx]--;
      if (bcnt_m < 65535) bcnt_m++;
      if (bcnt4_m < 15) bcnt4_m++;
    end
    if (mp) begin
      if (mcnt_m < 65535) mcnt_m++;
      if (mcnt4_m < 15) mcnt4_m++;
    end
  endfunction

  task automatic check_all(input string tag);
    logic isb, eq, lt, tk, mp;
    model_comb(isb, eq, lt, tk, mp);
    check({tag, "_pred"}, 64'(f_pred), 64'(model_pred()));
    check({tag, "_breq"}, 64'(breq), 64'(eq));
    check({tag, "_brlt"}, 64'(brlt), 64'(lt));
    check({tag, "_taken"}, 64'(taken), 64'(tk));
    check({tag, "_mis"}, 64'(mis), 64'(mp));
    check({tag, "_bcnt"}, 64'(bcnt), 64'(bcnt_m));
    check({tag, "_mcnt"}, 64'(mcnt), 64'(mcnt_m));
    check({tag, "_bcnt4"}, 64'(bcnt4), 64'(bcnt4_m));
    check({tag, "_mcnt4"}, 64'(mcnt4), 64'(mcnt4_m));
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic p);
    ex_valid = v; ex_opcode = opc; ex_funct3 = f3; ex_pc = pc;
    ex_rs1 = a; ex_rs2 = b; ex_pred = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ex_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_bcnt", 64'(bcnt), 64'd0);
    check("rst_mcnt", 64'(mcnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, m0;
    logic [0:5] sat_exp;

    vecs[0]  = '{1'b1, 7'h63, 3'd4, 32'hFFFF_FFFF, 32'h1,          1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1};
    vecs[1]  = '{1'b1, 7'h63, 3'd6, 32'hFFFF_FFFF, 32'h1,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
    vecs[2]  = '{1'b1, 7'h63, 3'd1, 32'd5,         32'd5,          1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[3]  = '{1'b1, 7'h63, 3'd2, 32'd5,         32'd5,          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[4]  = '{1'b1, 7'h63, 3'd0, 32'd7,         32'd7,          1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0};
    vecs[5]  = '{1'b1, 7'h63, 3'd5, 32'd3,         32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1};
    vecs[6]  = '{1'b1, 7'h63, 3'd7, 32'd3,         32'hFFFF_FFFE,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1};
    vecs[7]  = '{1'b1, 7'h33, 3'd0, 32'd9,         32'd9,          1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[8]  = '{1'b0, 7'h63, 3'd0, 32'd4,         32'd4,          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[9]  = '{1'b1, 7'h63, 3'd4, 32'h8000_0000, 32'h7FFF_FFFF,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[10] = '{1'b1, 7'h63, 3'd1, 32'd1,         32'd2,          1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1};
    vecs[11] = '{1'b1, 7'h63, 3'd3, 32'd0,         32'd1,          1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};

    // Reset state, observed while reset is held.
    model_reset();
    f_valid = 1'b1;
    f_pc = 32'h100;
    #12;
    check("inrst_pred", 64'(f_pred), 64'd0);
    check("inrst_bcnt", 64'(bcnt), 64'd0);
    check("inrst_mcnt", 64'(mcnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: combinational outcome and per-edge counter deltas.
    f_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      set_ex(vecs[k].v, vecs[k].opc, vecs[k].f3, 32'h1000 + 32'(4 * k),
             vecs[k].rs1, vecs[k].rs2, vecs[k].pred);
      #1;
      check($sformatf("tbl%0d_breq", k), 64'(breq), 64'(vecs[k].breq));
      check($sformatf("tbl%0d_brlt", k), 64'(brlt), 64'(vecs[k].brlt));
      check($sformatf("tbl%0d_taken", k), 64'(taken), 64'(vecs[k].taken));
      check($sformatf("tbl%0d_mis", k), 64'(mis), 64'(vecs[k].mis));
      b0 = int'(bcnt);
      m0 = int'(mcnt);
      clock_edge();
      check($sformatf("tbl%0d_dbr", k), 64'(int'(bcnt) - b0), 64'(vecs[k].db));
      check($sformatf("tbl%0d_dmis", k), 64'(int'(mcnt) - m0), 64'(vecs[k].dm));
      check_all($sformatf("tbl%0d", k));
    end

    // Saturation at 0x100: 4 taken, then 2 not-taken.
    do_reset();
    sat_exp = 6'b111110;
    f_valid = 1'b1;
    f_pc = 32'h100;
    set_ex(1'b1, 7'h63, 3'd0, 32'h100, 32'd1, 32'd1, 1'b0);
    #1;
    check("sat_init_pred", 64'(f_pred), 64'd0);
    for (int k = 0; k < 6; k++) begin
      if (k >= 4) ex_rs2 = 32'd2;
      clock_edge();
      check($sformatf("sat%0d_pred", k), 64'(f_pred), 64'(sat_exp[k]));
      check_all($sformatf("sat%0d", k));
    end

    // Aliasing 0x200 onto 0x100: same-cycle fetch sees old state.
    set_ex(1'b1, 7'h63, 3'd0, 32'h200, 32'd3, 32'd3, 1'b0);
    #1;
    check("alias_old_pred", 64'(f_pred), 64'd0);
    clock_edge();
    ex_valid = 1'b0;
    #1;
    check("alias_new_pred", 64'(f_pred), 64'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      f_valid   = ($urandom_range(0, 9) != 0);
      f_pc      = {$urandom_range(0, 3), 22'd0, 8'($urandom_range(0, 255))};
      ex_valid  = ($urandom_range(0, 9) != 0);
      ex_opcode = ($urandom_range(0, 3) != 0) ? 7'h63 : 7'($urandom);
      ex_funct3 = 3'($urandom);
      ex_pc     = {$urandom_range(0, 3), 22'd0, 8'($urandom_range(0, 255))};
      ex_rs1    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      ex_rs2    = ($urandom_range(0, 3) == 0) ? ex_rs1
                : (($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)));
      ex_pred   = 1'($urandom);
      #1;
      check_all("rnd");
      clock_edge();
    end

    // Counter saturation with CWIDTH=4, then asynchronous reset mid-stream.
    do_reset();
    f_valid = 1'b1;
    f_pc = 32'h100;
    set_ex(1'b1, 7'h63, 3'd0, 32'h100, 32'd8, 32'd8, 1'b1);
    for (int n = 0; n < 20; n++) clock_edge();
    check("sat4_bcnt", 64'(bcnt4), 64'd15);
    check("sat16_bcnt", 64'(bcnt), 64'd20);
    check("sat4_mcnt", 64'(mcnt4), 64'd0);
    check("sat4_pred", 64'(f_pred), 64'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_bcnt", 64'(bcnt), 64'd0);
    check("arst_bcnt4", 64'(bcnt4), 64'd0);
    check("arst_pred", 64'(f_pred), 64'd0);
    clock_edge();
    check("rsthold_bcnt", 64'(bcnt), 64'd0);
    check("rsthold_pred", 64'(f_pred), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clock_edge();
    check("first_edge_bcnt", 64'(bcnt), 64'd1);
    check("first_edge_pred", 64'(f_pred), 64'd1);
    check_all("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
